// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: 2-FF sync, tick-sampled integrator, press/release/long pulses.
// Optional auto-repeat of o_press while held long is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_debounce_multi #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SAMPLE_HZ      = 1_000,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned LONG_TICKS     = 1_000,
  parameter int unsigned REPEAT_TICKS   = 200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic            o_tick
);

  localparam int unsigned TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned TW       = $clog2(TICK_DIV);
  localparam int unsigned CW       = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;

  logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
  logic                    tick;
  logic [N_CH-1:0]         sync1_q, sync2_q;
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]         level_q, level_d, rise, fall;
  state_e                  state_q [N_CH];
  state_e                  state_d [N_CH];
  logic [N_CH-1:0][HW-1:0] hold_q, hold_d;
  logic [N_CH-1:0]         long_q, long_d, press_q, press_d, release_q, release_d, rep;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Integrator: STABLE_SAMPLES consecutive disagreeing samples flip the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (tick) begin
        if (sync2_q[i] != level_q[i]) begin
          if (cnt_q[i] == CW'(STABLE_SAMPLES - 1)) begin
            level_d[i] = ~level_q[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      level_q    <= '0;
      hold_q     <= '0;
      long_q     <= '0;
      press_q    <= '0;
      release_q  <= '0;
      for (int i = 0; i < int'(N_CH); i++) state_q[i] <= StIdle;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      hold_q     <= hold_d;
      long_q     <= long_d;
      press_q    <= press_d;
      release_q  <= release_d;
      for (int i = 0; i < int'(N_CH); i++) state_q[i] <= state_d[i];
    end
  end

  // Next-state: a fall always wins over a long-press completing in the same tick.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        StIdle: if (rise[i]) state_d[i] = StHeld;
        StHeld: begin
          if (fall[i]) state_d[i] = StIdle;
          else if (tick && hold_q[i] == HW'(LONG_TICKS - 1)) state_d[i] = StLong;
        end
        StLong: if (fall[i]) state_d[i] = StIdle;
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // hold_q counts samples toward the long press in StHeld, then repeat periods in StLong.
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    rep    = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      case (state_q[i])
        StHeld: begin
          if (fall[i]) begin
            hold_d[i] = '0;
          end else if (tick) begin
            if (hold_q[i] == HW'(LONG_TICKS - 1)) begin
              long_d[i] = 1'b1;
              hold_d[i] = '0;
            end else if (hold_q[i] != HW'(HOLD_MAX)) begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
          end
        end
        StLong: begin
          if (fall[i]) begin
            hold_d[i] = '0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (tick) begin
            if (hold_q[i] == HW'(REPEAT_TICKS - 1)) begin
              rep[i]    = 1'b1;
              hold_d[i] = '0;
            end else if (hold_q[i] != HW'(HOLD_MAX)) begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
          end
`endif
        end
        default: hold_d[i] = '0;
      endcase
    end
    press_d   = rise | rep;
    release_d = fall;
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_tick    = tick;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: a per-sample reference model pushes expected pulse
// events; an independent monitor matches every DUT pulse and checks level/tick each clock.
module tb_btn_debounce_multi;

  localparam int N      = 4;
  localparam int DIV    = 10;
  localparam int STABLE = 4;
  localparam int LONGT  = 8;
  localparam int REPT   = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] o_level, o_press, o_release, o_long;
  logic         o_tick;

  btn_debounce_multi #(
    .N_CH(N), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(STABLE),
    .LONG_TICKS(LONGT), .REPEAT_TICKS(REPT)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_long(o_long), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int kind; int ch;} ev_t;  // kind: 0 press, 1 release, 2 long
  ev_t sb[$];

  int           checks = 0;
  int           errors = 0;
  int           mcyc;
  logic [N-1:0] mlvl, h1, h2;
  int           run [N];
  int           held [N];
  int           rep [N];
  bit           longd [N];

  task automatic push(input int k, input int ch);
    ev_t e;
    e.cyc = mcyc; e.kind = k; e.ch = ch;
    sb.push_back(e);
  endtask

  // Reference model: one step per clock; inputs reach the sampler two clocks late.
  always @(posedge clk) begin : model
    logic [N-1:0] samp;
    bit flipped;
    if (reset) begin
      mcyc = 0; mlvl = '0; h1 = '0; h2 = '0;
      sb.delete();
      for (int c = 0; c < N; c++) begin run[c] = 0; held[c] = 0; rep[c] = 0; longd[c] = 0; end
    end else begin
      mcyc++;
      samp = h2; h2 = h1; h1 = i_btn;
      if (mcyc % DIV == 0) begin
        for (int c = 0; c < N; c++) begin
          flipped = 0;
          if (samp[c] != mlvl[c]) begin
            run[c]++;
            if (run[c] == STABLE) begin
              mlvl[c] = ~mlvl[c];
              run[c] = 0;
              flipped = 1;
              if (mlvl[c]) begin push(0, c); held[c] = 0; longd[c] = 0; end
              else push(1, c);
            end
          end else begin
            run[c] = 0;
          end
          if (!flipped && mlvl[c]) begin
            if (!longd[c]) begin
              held[c]++;
              if (held[c] == LONGT) begin push(2, c); longd[c] = 1; rep[c] = 0; end
            end
`ifdef BTN_AUTO_REPEAT_EN
            else begin
              rep[c]++;
              if (rep[c] == REPT) begin push(0, c); rep[c] = 0; end
            end
`endif
          end
        end
      end
    end
  end

  // Monitor: sample 1 time unit after the active edge.
  always @(posedge clk) begin : monitor
    logic pulse;
    int   idx;
    #1;
    if (reset) begin
      checks++;
      if ({o_level, o_press, o_release, o_long, o_tick} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b lng=%b tick=%b want all 0",
                 o_level, o_press, o_release, o_long, o_tick);
      end
    end else begin
      checks++;
      if (o_level !== mlvl) begin
        errors++;
        $display("FAIL level cyc=%0d got %b want %b", mcyc, o_level, mlvl);
      end
      checks++;
      if (o_tick !== ((mcyc + 1) % DIV == 0)) begin
        errors++;
        $display("FAIL tick cyc=%0d got %b want %b", mcyc, o_tick, (mcyc + 1) % DIV == 0);
      end
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < N; c++) begin
          pulse = (k == 0) ? o_press[c] : (k == 1) ? o_release[c] : o_long[c];
          if (pulse !== 1'b0) begin
            checks++;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].cyc == mcyc && sb[i].kind == k && sb[i].ch == c) idx = i;
            if (idx < 0) begin
              errors++;
              $display("FAIL unexpected_pulse cyc=%0d kind=%0d ch=%0d got %b want 0",
                       mcyc, k, c, pulse);
            end else begin
              sb.delete(idx);
            end
          end
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= mcyc) begin
          checks++;
          errors++;
          $display("FAIL missed_pulse cyc=%0d kind=%0d ch=%0d got 0 want 1",
                   sb[i].cyc, sb[i].kind, sb[i].ch);
          sb.delete(i);
        end
      end
    end
  end

  task automatic hold_for(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int           left [N];
    logic [N-1:0] tgt;
    logic [N-1:0] glitch;

    // All buttons held through reset, then released reset.
    i_btn = 4'b1111;
    reset = 1'b1;
    hold_for(5);
    reset = 1'b0;
    hold_for(60);
    i_btn = 4'b0000;
    hold_for(60);

    // ch0 bouncing on successive ticks, then steady.
    for (int b = 0; b < 4; b++) begin
      i_btn[0] = (b % 2 == 0);
      hold_for(DIV);
    end
    i_btn[0] = 1'b1;
    hold_for(70);
    i_btn[0] = 1'b0;
    hold_for(60);

    // ch1 long hold of 20 ticks.
    i_btn[1] = 1'b1;
    hold_for(20 * DIV);
    i_btn[1] = 1'b0;
    hold_for(60);

    // ch2: one-clock glitch, then a 3-tick pulse; neither may register.
    i_btn[2] = 1'b1;
    hold_for(1);
    i_btn[2] = 1'b0;
    hold_for(25);
    i_btn[2] = 1'b1;
    hold_for(3 * DIV);
    i_btn[2] = 1'b0;
    hold_for(60);

    // ch0 and ch3 together, reset asserted mid-hold.
    i_btn = 4'b1001;
    hold_for(100);
    reset = 1'b1;
    hold_for(3);
    reset = 1'b0;
    i_btn = 4'b0000;
    hold_for(60);

    // Random per-channel levels with occasional single-clock glitches and one mid-run reset.
    for (int c = 0; c < N; c++) left[c] = 0;
    tgt = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (left[c] == 0) begin
          tgt[c]  = 1'($urandom_range(0, 1));
          left[c] = $urandom_range(1, 160);
        end
        left[c]--;
      end
      glitch = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      i_btn  = tgt ^ glitch;
      if (cyc == 2000) reset = 1'b1;
      if (cyc == 2003) reset = 1'b0;
      @(negedge clk);
    end

    i_btn = '0;
    hold_for(80);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending events want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
Parametrised multi-channel push-button conditioner that replaces the single-channel 4-FF debouncer. Each channel is synchronised, then debounced by a saturating integrator clocked by a shared single-cycle sample-enable. The block outputs a clean level plus one-clock press, release and long-press pulses. It sits between the board buttons and the top-level control FSMs, such as the sensor mode and trigger selection.

Parameters:
N_CH, 4, number of independent button channels
CLK_HZ, 100_000_000, system clock frequency in Hz
SAMPLE_HZ, 1_000, sample-enable rate; TICK_DIV = CLK_HZ/SAMPLE_HZ (integer, >=2)
STABLE_SAMPLES, 4, consecutive disagreeing samples needed to flip the debounced level (>=1)
LONG_TICKS, 1_000, held samples after press before o_long fires (>=1)
REPEAT_TICKS, 200, auto-repeat period in samples; used only with AUTO_REPEAT_EN (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high; clears every register
i_btn  input  N_CH  raw asynchronous button inputs, 1 = pressed
o_level  output  N_CH  debounced level per channel
o_press  output  N_CH  one-clk pulse on each debounced 0->1 (plus repeats if enabled)
o_release  output  N_CH  one-clk pulse on each debounced 1->0
o_long  output  N_CH  one-clk pulse when held LONG_TICKS samples
o_tick  output  1  shared sample-enable, for debug/reuse

Behaviour:
- Reset: all outputs 0, tick counter 0, synchronisers 0, integrators 0, all channel FSMs in IDLE. Reset mid-press drops o_level to 0 with no o_release pulse.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. o_tick=1 for exactly one clk when counter==TICK_DIV-1. No derived clocks; all state uses clk with a tick enable.
- Sync: two FFs per channel. sync = i_btn delayed 2 clk.
- Integrator, per channel, updated only on tick:
  - If sync==o_level, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - When the mismatch is seen with cnt==STABLE_SAMPLES-1: o_level<=~o_level, cnt<=0.
  - cnt width is $clog2(STABLE_SAMPLES+1). A single agreeing sample restarts the count.
- Pulses are registered in the same clk that o_level changes, and last exactly 1 clk:
  - o_press when o_level goes 0->1.
  - o_release when o_level goes 1->0.
- Latency from a stable input edge: 2 clk sync, plus 1..TICK_DIV clk to the first tick, plus (STABLE_SAMPLES-1)*TICK_DIV clk.
- Channel FSM, one per channel:
  - IDLE: o_level=0. On level rise go to HELD with hold<=0.
  - HELD: on each tick hold<=hold+1. When hold reaches LONG_TICKS-1 on a tick, pulse o_long and go to LONG. On level fall go to IDLE.
  - LONG: on level fall go to IDLE. o_long never re-fires within one press.
  - hold saturates and never wraps. Width is $clog2(max(LONG_TICKS,REPEAT_TICKS)+1).
- Channels are fully independent. Simultaneous events on different channels each produce their own pulse in the same clk.
- A release in the same tick that would complete LONG_TICKS: release wins, o_release pulses, o_long does not.

Optional Feature:
Macro BTN_AUTO_REPEAT_EN.
- Defined: in LONG, a repeat counter runs on ticks. Every REPEAT_TICKS samples o_press pulses one clk. The first repeat comes REPEAT_TICKS samples after o_long. The counter clears on entry to LONG and on release.
- Undefined: no repeat logic is synthesised. o_press fires exactly once per debounced press.

Test Plan:
Use CLK_HZ=1000, SAMPLE_HZ=100 (TICK_DIV=10), STABLE_SAMPLES=4, LONG_TICKS=8, REPEAT_TICKS=3, N_CH=4.
1. Reset with i_btn=4'b1111 held -> all outputs 0 while reset is high. After release, o_level=4'b1111 within 2+10+30=42 clk, with one o_press pulse per channel.
2. ch0 bounce 1,0,1,0 on successive ticks, then steady 1 -> o_level[0] rises exactly 4 ticks after the last 0 sample. Exactly one o_press[0] and no o_release[0].
3. ch1 held 1 for 20 ticks -> o_long[1] pulses once, 8 ticks after o_press[1]. On release, o_release[1] pulses 4 ticks after the input falls.
4. ch2 1-clk glitch between ticks, or a 3-tick pulse -> o_level[2] stays 0 and no pulses.
5. ch0 and ch3 pressed in the same clk -> o_press[0] and o_press[3] are asserted in the same clk. Asserting reset mid-hold -> o_level=0, no o_release, FSM back in IDLE.
6. With BTN_AUTO_REPEAT_EN defined, ch1 held 20 ticks -> o_press[1] fires at press, then at o_long+3, +6, +9 ticks. Without the macro, o_press[1] fires only once.
